// File: rtl/instr_pkg.sv
// Shared instruction/pipeline constants and types.
// Register-write tracking parameters live here too.
package instr_pkg;

  localparam int RV_NUM_REGS = 32;

  localparam int REGWR_MAX_OUTST = 3;

  typedef logic [$clog2(REGWR_MAX_OUTST+1)-1:0] t_regwr_cnt;

endpackage

// File: rtl/regwr_cnt_cell.sv
// Per-register outstanding-write counter.
// Up on dispatch, down on writeback, cleared on flush.
module regwr_cnt_cell #(
  parameter int MAX_OUTST = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic dec_i,
  input  logic clr_i,
  output logic busy_o,
  output logic full_o
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_OUTST);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign busy_o = (cnt_q != '0);
  assign full_o = (cnt_q == CMAX);

  // Next count; inc and dec together cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i && !full_o) begin
      cnt_d = cnt_q + CW'(1);
    end else if (dec_i && !inc_i && busy_o) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regwr_tracker.sv
// Tracks outstanding register writes between RD and RB.
// Stalls dispatch on RAW hazards and counter saturation.
module regwr_tracker
  import instr_pkg::*;
#(
  parameter int MAX_OUTST = REGWR_MAX_OUTST
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   disp_valid,
  input  logic                   disp_wr,
  input  logic [4:0]             disp_rd,
  input  logic [RV_NUM_REGS-1:0] disp_src_mask,
  output logic                   disp_ready,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  input  logic                   flush,
  output logic [RV_NUM_REGS-1:0] busy_mask,
  output logic                   underflow_err
);

  logic [RV_NUM_REGS-1:0] busy;
  logic [RV_NUM_REGS-1:0] full;
  logic raw_haz;
  logic sat_haz;
  logic disp_fire;
  logic wb_fire;
  logic underflow_d;
  logic underflow_q;

  // x0 is never tracked.
  assign busy[0] = 1'b0;
  assign full[0] = 1'b0;

  assign busy_mask     = busy;
  assign underflow_err = underflow_q;

  assign raw_haz = |(disp_src_mask & busy);
  assign sat_haz = disp_wr && (disp_rd != '0)
                && full[disp_rd];

  assign disp_ready = !raw_haz && !sat_haz;

  assign disp_fire = disp_valid && disp_ready
                  && disp_wr && (disp_rd != '0)
                  && !flush;

  assign wb_fire = wb_valid && (wb_rd != '0)
                && !flush;

  assign underflow_d = underflow_q
                    || (wb_fire && !busy[wb_rd]);

  for (genvar i = 1; i < RV_NUM_REGS; i++) begin : g_cell
    regwr_cnt_cell #(
      .MAX_OUTST(MAX_OUTST)
    ) u_cell (
      .clk   (clk),
      .rst_n (reset_n),
      .inc_i (disp_fire && (disp_rd == 5'(i))),
      .dec_i (wb_fire && (wb_rd == 5'(i))),
      .clr_i (flush),
      .busy_o(busy[i]),
      .full_o(full[i])
    );
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: doc/regwr_tracker.md
REGWR_TRACKER -- requirements
Module: regwr_tracker

Interface
REQ-001 SHALL have parameter MAX_OUTST, default 3, meaning maximum outstanding writes tracked per architectural register (range 1..3).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port disp_valid  input  1  a uop requests dispatch from DE1 into RD.
REQ-005 SHALL have port disp_wr  input  1  the dispatching uop writes a destination register.
REQ-006 SHALL have port disp_rd  input  5  destination register index of the dispatching uop.
REQ-007 SHALL have port disp_src_mask  input  RV_NUM_REGS  read mask of the dispatching uop.
REQ-008 SHALL have port disp_ready  output  1  dispatch accepted this cycle when high with disp_valid.
REQ-009 SHALL have port wb_valid  input  1  a uop retires its register write in RB.
REQ-010 SHALL have port wb_rd  input  5  register index being written back.
REQ-011 SHALL have port flush  input  1  kill all in-flight uops younger than RB.
REQ-012 SHALL have port busy_mask  output  RV_NUM_REGS  registers with one or more writes outstanding.
REQ-013 SHALL have port underflow_err  output  1  sticky: writeback arrived with zero writes outstanding.

Function
REQ-014 SHALL keep one saturating counter per register, width clog2(MAX_OUTST+1).
REQ-015 SHALL never track register 0; its counter is tied to 0 and busy_mask[0] is always 0.
REQ-016 SHALL compute busy_mask[i] = (cnt[i] != 0), from registered state only.
REQ-017 SHALL drive disp_ready low when (disp_src_mask & busy_mask) != 0 (RAW hazard).
REQ-018 SHALL drive disp_ready low when disp_wr, disp_rd != 0, and cnt[disp_rd] == MAX_OUTST (saturation).
REQ-019 SHALL otherwise drive disp_ready high; disp_ready does not depend on disp_valid.
REQ-020 SHALL count a dispatch as disp_valid & disp_ready & disp_wr & (disp_rd != 0); cnt[disp_rd] increments at the next edge.
REQ-021 SHALL decrement cnt[wb_rd] at the next edge on wb_valid when wb_rd != 0 and cnt[wb_rd] != 0.
REQ-022 SHALL leave cnt unchanged when a counted dispatch and a writeback target the same register in the same cycle.
REQ-023 SHALL apply a counted dispatch and a writeback to different registers independently in the same cycle.
REQ-024 SHALL set underflow_err on wb_valid with wb_rd != 0 and cnt[wb_rd] == 0, leave the counter at 0, and hold the flag until reset.
REQ-025 SHALL, on flush, clear all counters at the next edge, except that a same-cycle wb_valid is discarded, not counted, and does not raise underflow_err.
REQ-026 SHALL ignore a dispatch in a flush cycle: no counter change, while disp_ready still follows REQ-017 to REQ-019.
REQ-027 SHALL make busy_mask reflect a dispatch or writeback exactly one cycle after the qualifying edge.
REQ-028 SHALL give a zero-cycle dispatch-to-busy bypass: none; back-to-back dependent uops stall one cycle minimum.

Reset
REQ-029 SHALL, while reset_n is low, force all counters to 0, busy_mask to 0, and underflow_err to 0, asynchronously.
REQ-030 SHALL drive disp_ready high during reset.
REQ-031 SHALL drop any dispatch or writeback in flight when reset asserts mid-operation; state after deassertion is the reset state.

Structure
REQ-032 SHALL take RV_NUM_REGS from the shared instr package.
REQ-033 SHALL add constant REGWR_MAX_OUTST and typedef t_regwr_cnt to the instr package.
REQ-034 SHALL use one sub-module regwr_cnt_cell: a per-register up/down/clear counter with a busy output, instanced for registers 1..31.

Verification
REQ-035 SHALL cover single dispatch then writeback: dispatch wr x5; busy_mask[5] = 1 next cycle; wb x5; busy_mask[5] = 0 one cycle later.
REQ-036 SHALL cover RAW stall: x5 busy; disp_src_mask bit 5 set; disp_ready = 0 until the cycle after wb x5, then 1.
REQ-037 SHALL cover saturation: 3 dispatches to x7 with MAX_OUTST = 3; 4th sees disp_ready = 0; one wb x7 restores disp_ready = 1 next cycle.
REQ-038 SHALL cover simultaneous events: cnt[x9] = 1; dispatch x9 and wb x9 same cycle; cnt stays 1 and busy holds.
REQ-039 SHALL cover flush and x0: dispatches to x3, x4, and x0; flush; all busy = 0 next cycle; busy_mask[0] never set.
REQ-040 SHALL cover underflow and reset: wb x12 at cnt 0 sets underflow_err, which holds; reset_n low mid-stream zeroes all outputs immediately.
